// File: rtl/alu_mc.sv
// alu_mc: multi-cycle signed ALU for the CPU datapath.
//
// Single-cycle ops (add/sub/logic/shift/branch/illegal) finish in one clock. Multiply runs an
// iterative shift-add and divide/remainder a restoring divider, both on operand magnitudes, for
// WIDTH clocks, with sign correction and exception handling applied at the final edge.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset, aborts any op in flight
//   start       - request, sampled only while busy=0
//   a, b        - signed operands, captured with start
//   s           - 4-bit opcode, captured with start
//   f           - registered result, held until the next completed op
//   take_branch - registered branch decision
//   ovf         - registered overflow / exception flag
//   busy        - high while a multi-cycle op runs
//   done        - one-cycle pulse when f/take_branch/ovf update
//
// WIDTH must be a power of two and at least 4.

module alu_mc #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  output logic [WIDTH-1:0] f,
  output logic             take_branch,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [CntW-1:0]  CntLoad = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpNot  = 4'h1;
  localparam logic [3:0] OpAnd  = 4'h2;
  localparam logic [3:0] OpOr   = 4'h3;
  localparam logic [3:0] OpAsr  = 4'h4;
  localparam logic [3:0] OpShl  = 4'h5;
  localparam logic [3:0] OpBeqz = 4'h6;
  localparam logic [3:0] OpBnez = 4'h7;
  localparam logic [3:0] OpXor  = 4'h8;
  localparam logic [3:0] OpSub  = 4'h9;
  localparam logic [3:0] OpMul  = 4'hA;
  localparam logic [3:0] OpDiv  = 4'hB;
  localparam logic [3:0] OpRem  = 4'hC;
  localparam logic [3:0] OpBlt  = 4'hD;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] mcand_q;   // multiplicand (mul) or divisor magnitude (div/rem)
  logic [WIDTH-1:0] hi_q;      // product high half (mul) or partial remainder (div/rem)
  logic [WIDTH-1:0] lo_q;      // multiplier bits (mul) or dividend/quotient bits (div/rem)
  logic [WIDTH-1:0] a_q;
  logic             neg_q;     // product/quotient is negative
  logic             sign_a_q;  // remainder takes the sign of a
  logic             div0_q;
  logic             divovf_q;  // MIN / -1
  logic [WIDTH-1:0] f_q;
  logic             tb_q;
  logic             ovf_q;
  logic             done_q;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated directly from the inputs
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic             big_shift;
  logic [WIDTH-1:0] asr_res;
  logic [WIDTH-1:0] shl_res;
  logic             is_multi;
  logic [WIDTH-1:0] sc_f;
  logic             sc_tb;
  logic             sc_ovf;

  // One extra sign bit exposes signed overflow as a mismatch of the top two bits.
  assign add_ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign sub_ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};

  // WIDTH is a power of two, so b >= WIDTH exactly when any bit above the shift field is set.
  assign big_shift = |b[WIDTH-1:ShW];
  assign asr_res   = big_shift ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b[ShW-1:0]);
  assign shl_res   = big_shift ? '0 : (a << b[ShW-1:0]);

  assign is_multi = (s == OpMul) || (s == OpDiv) || (s == OpRem);

  always_comb begin
    sc_f   = '0;
    sc_tb  = 1'b0;
    sc_ovf = 1'b0;
    unique case (s)
      OpAdd: begin
        sc_f   = add_ext[WIDTH-1:0];
        sc_ovf = add_ext[WIDTH] ^ add_ext[WIDTH-1];
      end
      OpNot:  sc_f = ~b;
      OpAnd:  sc_f = a & b;
      OpOr:   sc_f = a | b;
      OpAsr:  sc_f = asr_res;
      OpShl:  sc_f = shl_res;
      OpBeqz: sc_tb = (a == '0);
      OpBnez: sc_tb = (a != '0);
      OpXor:  sc_f = a ^ b;
      OpSub: begin
        sc_f   = sub_ext[WIDTH-1:0];
        sc_ovf = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];
      end
      OpBlt:  sc_tb = ($signed(a) < $signed(b));
      OpMul, OpDiv, OpRem: begin
        // Handled by the iterative path.
      end
      default: begin
        sc_tb  = 1'b1;
        sc_ovf = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // Magnitude of MIN is 2^(WIDTH-1), which still fits as an unsigned WIDTH value.
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  // Shift-add step: add the multiplicand when the current multiplier bit is set, then shift
  // the {hi, lo} pair right, retiring one multiplier bit per step.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};

  // Restoring step: shift the next dividend bit into the remainder, subtract the divisor when
  // it fits, and shift the resulting quotient bit into lo.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_n;
  logic [WIDTH-1:0] div_lo_n;

  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mcand_q});
  assign div_sub   = div_shift - {1'b0, mcand_q};
  assign div_hi_n  = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo_n  = {lo_q[WIDTH-2:0], div_ge};

  logic [WIDTH-1:0] it_hi_n;
  logic [WIDTH-1:0] it_lo_n;

  assign it_hi_n = (op_q == OpMul) ? mul_hi_n : div_hi_n;
  assign it_lo_n = (op_q == OpMul) ? mul_lo_n : div_lo_n;

  // Final result, formed from the last iteration's outputs so no extra clock is needed.
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     prod_top;
  logic               mul_ovf;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;
  logic [WIDTH-1:0]   fin_f;
  logic               fin_ovf;

  assign prod_mag = {mul_hi_n, mul_lo_n};
  assign prod     = neg_q ? -prod_mag : prod_mag;
  // Product fits a signed WIDTH value only if bits [2W-1:W-1] are a pure sign extension.
  assign prod_top = prod[2*WIDTH-1:WIDTH-1];
  assign mul_ovf  = !((&prod_top) || (~|prod_top));

  assign quo = neg_q ? -div_lo_n : div_lo_n;
  assign rmd = sign_a_q ? -div_hi_n : div_hi_n;

  always_comb begin
    fin_f   = '0;
    fin_ovf = 1'b0;
    case (op_q)
      OpMul: begin
        fin_f   = prod[WIDTH-1:0];
        fin_ovf = mul_ovf;
      end
      OpDiv: begin
        if (div0_q) begin
          fin_f   = '1;
          fin_ovf = 1'b1;
        end else if (divovf_q) begin
          fin_f   = MinVal;
          fin_ovf = 1'b1;
        end else begin
          fin_f = quo;
        end
      end
      default: begin
        if (div0_q) begin
          fin_f   = a_q;
          fin_ovf = 1'b1;
        end else if (divovf_q) begin
          fin_f   = '0;
          fin_ovf = 1'b1;
        end else begin
          fin_f = rmd;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      div0_q   <= 1'b0;
      divovf_q <= 1'b0;
      f_q      <= '0;
      tb_q     <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (is_multi) begin
              op_q     <= s;
              // mul: multiplicand=|a|, multiplier=|b|; div/rem: divisor=|b|, dividend=|a|.
              mcand_q  <= (s == OpMul) ? abs_a : abs_b;
              lo_q     <= (s == OpMul) ? abs_b : abs_a;
              hi_q     <= '0;
              a_q      <= a;
              neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_a_q <= a[WIDTH-1];
              div0_q   <= (b == '0);
              divovf_q <= (a == MinVal) && (b == '1);
              cnt_q    <= CntLoad;
              state_q  <= StRun;
            end else begin
              f_q    <= sc_f;
              tb_q   <= sc_tb;
              ovf_q  <= sc_ovf;
              done_q <= 1'b1;
            end
          end
        end
        StRun: begin
          hi_q <= it_hi_n;
          lo_q <= it_lo_n;
          if (cnt_q == '0) begin
            f_q     <= fin_f;
            tb_q    <= 1'b0;
            ovf_q   <= fin_ovf;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign f           = f_q;
  assign take_branch = tb_q;
  assign ovf         = ovf_q;
  assign busy        = (state_q == StRun);
  assign done        = done_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   s = '0;
  logic [W-1:0] f;
  logic         take_branch;
  logic         ovf;
  logic         busy;
  logic         done;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .s(s),
    .f(f),
    .take_branch(take_branch),
    .ovf(ovf),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] f;
    logic         tb;
    logic         ovf;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: plain signed integer arithmetic on the operand values.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] av,
                                 input logic [W-1:0] bv);
    exp_t   e;
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    e.op = op; e.av = av; e.bv = bv;
    e.f = '0; e.tb = 1'b0; e.ovf = 1'b0; e.lat = 0; e.acc_cyc = 0;
    case (op)
      4'h0: begin r = sa + sb; e.f = r[W-1:0]; e.ovf = (r > 32767) || (r < -32768); end
      4'h1: e.f = ~bv;
      4'h2: e.f = av & bv;
      4'h3: e.f = av | bv;
      4'h4: begin
        if (bv >= 16) e.f = av[W-1] ? 16'hFFFF : 16'h0000;
        else begin r = sa >>> bv; e.f = r[W-1:0]; end
      end
      4'h5: begin
        if (bv >= 16) e.f = '0;
        else begin r = sa << bv; e.f = r[W-1:0]; end
      end
      4'h6: e.tb = (av == 0);
      4'h7: e.tb = (av != 0);
      4'h8: e.f = av ^ bv;
      4'h9: begin r = sa - sb; e.f = r[W-1:0]; e.ovf = (r > 32767) || (r < -32768); end
      4'hA: begin r = sa * sb; e.f = r[W-1:0]; e.ovf = (r > 32767) || (r < -32768); end
      4'hB: begin
        if (sb == 0) begin e.f = 16'hFFFF; e.ovf = 1'b1; end
        else if (sa == -32768 && sb == -1) begin e.f = 16'h8000; e.ovf = 1'b1; end
        else begin r = sa / sb; e.f = r[W-1:0]; end
      end
      4'hC: begin
        if (sb == 0) begin e.f = av; e.ovf = 1'b1; end
        else if (sa == -32768 && sb == -1) begin e.f = 16'h0000; e.ovf = 1'b1; end
        else begin r = sa % sb; e.f = r[W-1:0]; end
      end
      4'hD: e.tb = (sa < sb);
      default: begin e.tb = 1'b1; e.ovf = 1'b1; end
    endcase
    if (op == 4'hA || op == 4'hB || op == 4'hC) e.lat = W;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expectation.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got f=%h tb=%b ovf=%b expected no done", f, take_branch,
                 ovf);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if ({f, take_branch, ovf} !== {e.f, e.tb, e.ovf}) begin
          errors++;
          $display("FAIL result op=%h a=%h b=%h: got f=%h tb=%b ovf=%b expected f=%h tb=%b ovf=%b",
                   e.op, e.av, e.bv, f, take_branch, ovf, e.f, e.tb, e.ovf);
        end
        checks++;
        if (cyc - e.acc_cyc != e.lat) begin
          errors++;
          $display("FAIL latency op=%h: got %0d expected %0d", e.op, cyc - e.acc_cyc, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=1 expected busy=0 within 64 cycles");
    end
    a = av; b = bv; s = op; start = 1'b1;
    e = model(op, av, bv);
    e.acc_cyc = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = 16'h0000;
      1: v = 16'h0001;
      2: v = 16'hFFFF;
      3: v = 16'h8000;
      4: v = 16'h7FFF;
      5: v = W'($urandom_range(0, 40)) - 16'd20;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin : driver
    logic [3:0]   op;
    logic [W-1:0] av;
    logic [W-1:0] bv;

    // Reset state
    #1;
    chk("reset_f", f, 0);
    chk("reset_flags", {take_branch, ovf, busy, done}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vectors, issued back-to-back where possible
    issue(4'h0, 16'h7FFF, 16'h0001);
    issue(4'h9, 16'h8000, 16'h0001);
    issue(4'hA, 16'd12, 16'hFFF5);
    issue(4'hA, 16'd300, 16'hFF38);
    issue(4'hB, 16'hFFF9, 16'd2);
    issue(4'hC, 16'hFFF9, 16'd2);
    issue(4'hB, 16'd5, 16'd0);
    issue(4'hC, 16'd5, 16'd0);
    issue(4'hB, 16'h8000, 16'hFFFF);
    issue(4'hC, 16'h8000, 16'hFFFF);
    issue(4'h4, 16'h8000, 16'd20);
    issue(4'h5, 16'h0001, 16'd16);
    issue(4'hD, 16'hFFFF, 16'h0001);
    issue(4'h6, 16'h0000, 16'h1234);
    issue(4'hF, 16'h0001, 16'h0002);
    idle();
    drain();

    // Inputs changing and start pulsing during a multiply must be ignored
    issue(4'hA, 16'd12, 16'hFFF5);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (k == 1) chk("mul_busy", busy, 1);
      a = W'($urandom);
      b = W'($urandom);
      s = 4'($urandom);
      start = (k == 3 || k == 8);
    end
    @(negedge clk);
    start = 1'b0;
    chk("mul_busy_after", busy, 0);
    chk("mul_single_done", sb_q.size(), 0);

    // Reset in the middle of a divide
    issue(4'hB, 16'hFFF9, 16'd2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    #1;
    chk("midrun_reset_f", f, 0);
    chk("midrun_reset_flags", {take_branch, ovf, busy, done}, 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(4'h0, 16'd2, 16'd3);
    idle();
    drain();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      av = pick();
      bv = pick();
      if ((op == 4'h4 || op == 4'h5) && $urandom_range(0, 3) != 0) bv = W'($urandom_range(0, 20));
      issue(op, av, bv);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised ALU that replaces the single-cycle 16-bit ALU in the CPU datapath. It keeps the existing 4-bit opcode map and adds subtract, signed multiply, signed divide/remainder and signed branch-if-less-than. Operands are captured on a start/done handshake and results are registered. Single-cycle ops complete in 1 clock; multiply and divide run iteratively for WIDTH clocks. The control unit stalls on `busy`.

## Interface
- `WIDTH`, default 16: operand/result width in bits; must be ≥ 4 and a power of two.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only when `busy`=0.
- `a` input WIDTH: signed operand A.
- `b` input WIDTH: signed operand B.
- `s` input 4: opcode; sampled with `start`.
- `f` output WIDTH: registered result; holds until the next completed op.
- `take_branch` output 1: registered branch decision.
- `ovf` output 1: registered overflow / exception flag.
- `busy` output 1: high while a multi-cycle op is in progress.
- `done` output 1: one-cycle pulse when `f`, `take_branch` and `ovf` update.

## Operation
- Opcode map:
  - 0000 add, f=a+b; ovf = signed overflow.
  - 0001 f=~b.
  - 0010 and.
  - 0011 or.
  - 0100 arithmetic shift right, a>>>b.
  - 0101 logical shift left, a<<b.
  - 0110 beqz: take_branch = (a==0).
  - 0111 bnez: take_branch = (a!=0).
  - 1000 xor.
  - 1001 sub, f=a-b; ovf = signed overflow.
  - 1010 mul.
  - 1011 div.
  - 1100 rem.
  - 1101 blt: take_branch = (a<b), signed.
  - 1110, 1111: illegal.
- Default values: f=0 for all branch ops. take_branch=0 and ovf=0 unless a rule below sets them.
- Shifts: b is treated as unsigned. If b ≥ WIDTH, asr fills with a[WIDTH-1] and shl gives 0.
- mul: full 2·WIDTH signed product; f = low WIDTH bits. ovf=1 when the product does not fit a signed WIDTH value, i.e. upper WIDTH+1 bits are not all equal.
- div/rem: signed, quotient truncated toward zero, remainder takes the sign of a.
  - Divide by zero: div f=all ones, rem f=a, ovf=1.
  - a=MIN, b=-1: div f=MIN, rem f=0, ovf=1.
- Illegal opcode: f=0, ovf=1, take_branch=1; completes in 1 clock.
- FSM states:
  - IDLE (`busy`=0): on `start` with a single-cycle opcode, compute and register the result and stay in IDLE. On `start` with mul/div/rem, latch operands and opcode, load counter = WIDTH-1, go to RUN.
  - RUN (`busy`=1): one shift-add or restoring-subtract iteration per clock on operand magnitudes. When counter=0, apply sign correction and exceptions, register the outputs, pulse `done`, return to IDLE.
- `start` while `busy`=1 is ignored; operand and opcode changes during RUN have no effect.
- Reset, including mid-RUN: abort immediately. State=IDLE, counter=0, f=0, take_branch=0, ovf=0, busy=0, done=0.

## Timing
- Single-cycle op: `start` sampled at edge E0 → outputs valid and `done`=1 after E0, for one cycle.
- mul/div/rem: `start` at E0 → `busy`=1 after E0 through edge E(WIDTH). At E(WIDTH): outputs update, `done`=1, `busy`=0. Latency is WIDTH clocks.
- Back-to-back: `start` is accepted in every cycle where `busy`=0, including the cycle where `done`=1. Single-cycle ops therefore sustain 1 op/clock.
- Between completions, outputs hold their last value; `done` is never high for two consecutive cycles for the same op.

## Test plan (WIDTH=16)
- add 0x7FFF+0x0001 → after 1 clock: f=0x8000, ovf=1, done pulse; then sub 0x8000-0x0001 → f=0x7FFF, ovf=1.
- mul 12×(-11) → busy for 16 clocks, then f=0xFF7C, ovf=0. mul 300×(-200) → f=0x15A0, ovf=1.
- div -7/2 → f=0xFFFD; rem -7/2 → f=0xFFFF. div 5/0 → f=0xFFFF, ovf=1. rem 5/0 → f=0x0005, ovf=1. div 0x8000/0xFFFF → f=0x8000, ovf=1.
- asr 0x8000 by 20 → f=0xFFFF; shl 0x0001 by 16 → f=0. blt a=-1, b=1 → take_branch=1. beqz a=0 → take_branch=1, f=0. Opcode 1111 → f=0, ovf=1, take_branch=1.
- Start mul, change a/b/s and pulse `start` at clocks 3 and 8 → single done at clock 16 with the original result; no extra done.
- Start div, assert `rst` at clock 5 → all outputs 0 immediately. After release, add 2+3 → f=5 one clock later.
